// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: functional-unit result inputs, ROB state,
// flush request and the registered CDB broadcast.
interface wb_arbiter_if #(
    parameter int TAG_W  = 5,
    parameter int PREG_W = 7
);
    logic              alu_valid, b_valid, mem_valid;
    logic [TAG_W-1:0]  alu_rob_tag, b_rob_tag, mem_rob_tag;
    logic [PREG_W-1:0] alu_pd, b_pd, mem_pd;
    logic              alu_we, b_we, mem_we;
    logic [31:0]       alu_result, b_result, mem_result;
    logic              alu_ready, b_ready, mem_ready;
    logic [TAG_W-1:0]  rob_head;
    logic              mispredict;
    logic [TAG_W-1:0]  mispredict_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_rob_tag;
    logic [PREG_W-1:0] cdb_pd;
    logic              cdb_we;
    logic [31:0]       cdb_data;
    logic [1:0]        cdb_src;

    modport slave (
        input  alu_valid, b_valid, mem_valid,
        input  alu_rob_tag, b_rob_tag, mem_rob_tag,
        input  alu_pd, b_pd, mem_pd,
        input  alu_we, b_we, mem_we,
        input  alu_result, b_result, mem_result,
        output alu_ready, b_ready, mem_ready,
        input  rob_head, mispredict, mispredict_tag,
        output cdb_valid, cdb_rob_tag, cdb_pd, cdb_we, cdb_data, cdb_src
    );

    modport master (
        output alu_valid, b_valid, mem_valid,
        output alu_rob_tag, b_rob_tag, mem_rob_tag,
        output alu_pd, b_pd, mem_pd,
        output alu_we, b_we, mem_we,
        output alu_result, b_result, mem_result,
        input  alu_ready, b_ready, mem_ready,
        output rob_head, mispredict, mispredict_tag,
        input  cdb_valid, cdb_rob_tag, cdb_pd, cdb_we, cdb_data, cdb_src
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three per-unit result FIFOs, round-robin grant onto a
// registered CDB port, with squashing of results younger than a mispredict.
module wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5,
    parameter int PREG_W = 7
) (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic              v_q    [3][DEPTH];
    logic [TAG_W-1:0]  tag_q  [3][DEPTH];
    logic [PREG_W-1:0] pd_q   [3][DEPTH];
    logic              we_q   [3][DEPTH];
    logic [31:0]       data_q [3][DEPTH];
    logic [PW-1:0]     head_q [3];
    logic [PW-1:0]     tail_q [3];
    logic [CW-1:0]     cnt_q  [3];
    logic [1:0]        rr_q, rr_d;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [PREG_W-1:0] cdb_pd_q, cdb_pd_d;
    logic              cdb_we_q, cdb_we_d;
    logic [31:0]       cdb_data_q, cdb_data_d;
    logic [1:0]        cdb_src_q, cdb_src_d;

    logic              in_v    [3];
    logic [TAG_W-1:0]  in_tag  [3];
    logic [PREG_W-1:0] in_pd   [3];
    logic              in_we   [3];
    logic [31:0]       in_data [3];

    logic              v_post [3][DEPTH];
    logic              ready  [3];
    logic              cand   [3];
    logic              push   [3];
    logic              pop    [3];
    logic              found;
    logic [1:0]        gsel;
    logic [TAG_W-1:0]  mp_age;

    always_comb begin
        in_v[0]    = bus.alu_valid;   in_v[1]    = bus.b_valid;   in_v[2]    = bus.mem_valid;
        in_tag[0]  = bus.alu_rob_tag; in_tag[1]  = bus.b_rob_tag; in_tag[2]  = bus.mem_rob_tag;
        in_pd[0]   = bus.alu_pd;      in_pd[1]   = bus.b_pd;      in_pd[2]   = bus.mem_pd;
        in_we[0]   = bus.alu_we;      in_we[1]   = bus.b_we;      in_we[2]   = bus.mem_we;
        in_data[0] = bus.alu_result;  in_data[1] = bus.b_result;  in_data[2] = bus.mem_result;
    end

    // Age relative to the ROB head; modular subtraction handles tag wrap.
    assign mp_age = bus.mispredict_tag - bus.rob_head;

    function automatic logic squash(input logic [TAG_W-1:0] t);
        logic [TAG_W-1:0] a;
        a = t - bus.rob_head;
        return bus.mispredict && (a > mp_age);
    endfunction

    always_comb begin
        found = 1'b0;
        gsel  = 2'd0;
        for (int unsigned s = 0; s < 3; s++) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                v_post[s][i] = v_q[s][i] && !squash(tag_q[s][i]);
            ready[s] = (cnt_q[s] != CW'(DEPTH));
            cand[s]  = (cnt_q[s] != '0) && v_post[s][head_q[s]];
            push[s]  = in_v[s] && ready[s] && !squash(in_tag[s]);
        end
        for (int unsigned k = 0; k < 3; k++) begin
            int unsigned idx;
            idx = (32'(rr_q) + k) % 3;
            if (!found && cand[idx]) begin
                found = 1'b1;
                gsel  = 2'(idx);
            end
        end
        // Non-empty heads that are not candidates are bubbles and drain for free.
        for (int unsigned s = 0; s < 3; s++)
            pop[s] = (cnt_q[s] != '0) && (!cand[s] || (found && gsel == 2'(s)));

        rr_d        = rr_q;
        cdb_valid_d = found;
        cdb_tag_d   = cdb_tag_q;
        cdb_pd_d    = cdb_pd_q;
        cdb_we_d    = cdb_we_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (found) begin
            rr_d       = (gsel == 2'd2) ? 2'd0 : gsel + 2'd1;
            cdb_tag_d  = tag_q[gsel][head_q[gsel]];
            cdb_pd_d   = pd_q[gsel][head_q[gsel]];
            cdb_we_d   = we_q[gsel][head_q[gsel]];
            cdb_data_d = data_q[gsel][head_q[gsel]];
            cdb_src_d  = gsel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < 3; s++) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    v_q[s][i]    <= 1'b0;
                    tag_q[s][i]  <= '0;
                    pd_q[s][i]   <= '0;
                    we_q[s][i]   <= 1'b0;
                    data_q[s][i] <= '0;
                end
                head_q[s] <= '0;
                tail_q[s] <= '0;
                cnt_q[s]  <= '0;
            end
            rr_q        <= 2'd0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_pd_q    <= '0;
            cdb_we_q    <= 1'b0;
            cdb_data_q  <= '0;
            cdb_src_q   <= 2'd0;
        end else begin
            for (int unsigned s = 0; s < 3; s++) begin
                for (int unsigned i = 0; i < DEPTH; i++)
                    v_q[s][i] <= v_post[s][i];
                if (pop[s]) begin
                    v_q[s][head_q[s]] <= 1'b0;
                    head_q[s]         <= head_q[s] + 1'b1;
                end
                if (push[s]) begin
                    v_q[s][tail_q[s]]    <= 1'b1;
                    tag_q[s][tail_q[s]]  <= in_tag[s];
                    pd_q[s][tail_q[s]]   <= in_pd[s];
                    we_q[s][tail_q[s]]   <= in_we[s];
                    data_q[s][tail_q[s]] <= in_data[s];
                    tail_q[s]            <= tail_q[s] + 1'b1;
                end
                cnt_q[s] <= cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
            end
            rr_q        <= rr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_pd_q    <= cdb_pd_d;
            cdb_we_q    <= cdb_we_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign bus.alu_ready   = ready[0];
    assign bus.b_ready     = ready[1];
    assign bus.mem_ready   = ready[2];
    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_rob_tag = cdb_tag_q;
    assign bus.cdb_pd      = cdb_pd_q;
    assign bus.cdb_we      = cdb_we_q;
    assign bus.cdb_data    = cdb_data_q;
    assign bus.cdb_src     = cdb_src_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts each
// CDB broadcast and its cycle; a monitor checks the DUT against those predictions.
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
    localparam int PREG_W = 7;
    localparam int TMASK = (1 << TAG_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.TAG_W(TAG_W), .PREG_W(PREG_W)) bus ();

    wb_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PREG_W(PREG_W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    logic              in_v    [3];
    logic [TAG_W-1:0]  in_tag  [3];
    logic [PREG_W-1:0] in_pd   [3];
    logic              in_we   [3];
    logic [31:0]       in_data [3];
    logic [TAG_W-1:0]  rob_head;
    logic              mp;
    logic [TAG_W-1:0]  mtag;

    assign bus.alu_valid = in_v[0];   assign bus.b_valid = in_v[1];   assign bus.mem_valid = in_v[2];
    assign bus.alu_rob_tag = in_tag[0]; assign bus.b_rob_tag = in_tag[1]; assign bus.mem_rob_tag = in_tag[2];
    assign bus.alu_pd = in_pd[0];     assign bus.b_pd = in_pd[1];     assign bus.mem_pd = in_pd[2];
    assign bus.alu_we = in_we[0];     assign bus.b_we = in_we[1];     assign bus.mem_we = in_we[2];
    assign bus.alu_result = in_data[0]; assign bus.b_result = in_data[1]; assign bus.mem_result = in_data[2];
    assign bus.rob_head = rob_head;
    assign bus.mispredict = mp;
    assign bus.mispredict_tag = mtag;

    typedef struct {
        bit v;
        int tag;
        int pd;
        bit we;
        int data;
    } ent_t;

    typedef struct {
        int cyc;
        int tag;
        int pd;
        bit we;
        int data;
        int src;
    } exp_t;

    ent_t mq [3][$];
    exp_t exp_q [$];
    int   m_rr;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   seen [32];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int agef(int t);
        return (t - int'(rob_head)) & TMASK;
    endfunction

    function automatic bit younger(int t);
        return mp && (agef(t) > agef(int'(mtag)));
    endfunction

    // One cycle of the reference model, using the inputs presented this cycle.
    task automatic model_step();
        bit   rdy [3];
        bit   cand [3];
        int   g;
        exp_t e;
        for (int s = 0; s < 3; s++) begin
            rdy[s] = mq[s].size() < DEPTH;
            for (int i = 0; i < mq[s].size(); i++)
                if (younger(mq[s][i].tag)) mq[s][i].v = 0;
            cand[s] = mq[s].size() > 0 && mq[s][0].v;
        end
        g = -1;
        for (int k = 0; k < 3; k++)
            if (g < 0 && cand[(m_rr + k) % 3]) g = (m_rr + k) % 3;
        if (g >= 0) begin
            e.cyc  = cyc + 1;
            e.tag  = mq[g][0].tag;
            e.pd   = mq[g][0].pd;
            e.we   = mq[g][0].we;
            e.data = mq[g][0].data;
            e.src  = g;
            exp_q.push_back(e);
            m_rr = (g + 1) % 3;
        end
        for (int s = 0; s < 3; s++) begin
            ent_t n;
            if (mq[s].size() > 0 && (!mq[s][0].v || s == g)) void'(mq[s].pop_front());
            if (in_v[s] && rdy[s] && !younger(int'(in_tag[s]))) begin
                n.v = 1; n.tag = int'(in_tag[s]); n.pd = int'(in_pd[s]);
                n.we = in_we[s]; n.data = int'(in_data[s]);
                mq[s].push_back(n);
            end
        end
    endtask

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic check_ready();
        chk("alu_ready", int'(bus.alu_ready), int'(mq[0].size() < DEPTH));
        chk("b_ready",   int'(bus.b_ready),   int'(mq[1].size() < DEPTH));
        chk("mem_ready", int'(bus.mem_ready), int'(mq[2].size() < DEPTH));
    endtask

    task automatic idle_inputs();
        for (int s = 0; s < 3; s++) begin
            in_v[s] = 0; in_tag[s] = '0; in_pd[s] = '0; in_we[s] = 0; in_data[s] = '0;
        end
        mp = 0;
        mtag = '0;
    endtask

    // Called at posedge+1 after inputs for the current cycle are set.
    task automatic tick();
        check_ready();
        model_step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic put(int s, int tag, int pd, bit we, int data);
        in_v[s] = 1; in_tag[s] = TAG_W'(tag); in_pd[s] = PREG_W'(pd);
        in_we[s] = we; in_data[s] = data;
    endtask

    task automatic drain(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL missing_grant: no broadcast seen, expected tag %0d src %0d in cycle %0d",
                         exp_q[0].tag, exp_q[0].src, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (bus.cdb_valid) begin
                seen[bus.cdb_rob_tag] = 1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_cdb: got valid tag %0d src %0d in cycle %0d, expected no broadcast",
                             bus.cdb_rob_tag, bus.cdb_src, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.tag != int'(bus.cdb_rob_tag) || e.pd != int'(bus.cdb_pd) ||
                        e.we != bus.cdb_we || e.data != int'(bus.cdb_data) || e.src != int'(bus.cdb_src)) begin
                        errors++;
                        $display("FAIL cdb_fields: got cyc %0d tag %0d pd %0d we %0d data %h src %0d; expected cyc %0d tag %0d pd %0d we %0d data %h src %0d",
                                 cyc, bus.cdb_rob_tag, bus.cdb_pd, bus.cdb_we, bus.cdb_data, bus.cdb_src,
                                 e.cyc, e.tag, e.pd, e.we, e.data[31:0], e.src);
                    end
                end
            end
        end
    end

    task automatic clear_model();
        for (int s = 0; s < 3; s++) mq[s].delete();
        exp_q.delete();
        m_rr = 0;
    endtask

    initial begin
        idle_inputs();
        rob_head = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cdb_valid", int'(bus.cdb_valid), 0);
        chk("rst_cdb_tag",   int'(bus.cdb_rob_tag), 0);
        chk("rst_cdb_pd",    int'(bus.cdb_pd), 0);
        chk("rst_cdb_we",    int'(bus.cdb_we), 0);
        chk("rst_cdb_data",  int'(bus.cdb_data), 0);
        chk("rst_cdb_src",   int'(bus.cdb_src), 0);
        check_ready();
        #2 rst = 0;
        @(posedge clk);
        #1;

        // Single ALU result, minimum latency
        put(0, 3, 10, 1, 32'hDEADBEEF);
        tick();
        drain(4);

        // All three sources in one cycle, round-robin order
        put(0, 4, 1, 1, 100); put(1, 5, 2, 0, 200); put(2, 6, 3, 1, 300);
        tick();
        drain(5);

        // Sustained load on every source to fill FIFOs and drop overflow
        for (int c = 0; c < 8; c++) begin
            for (int s = 0; s < 3; s++) put(s, (c * 3 + s) & TMASK, c, 1, c * 16 + s);
            tick();
        end
        drain(14);

        // Flush with rob_head=28, mispredict_tag=30
        rob_head = 5'd28;
        foreach (seen[i]) seen[i] = 0;
        put(0, 29, 1, 1, 29); put(1, 31, 2, 1, 31); put(2, 1, 3, 1, 1);
        tick();
        mp = 1; mtag = 5'd30; put(0, 2, 4, 1, 2);
        tick();
        drain(6);
        chk("flush_seen_29", int'(seen[29]), 1);
        chk("flush_seen_31", int'(seen[31]), 0);
        chk("flush_seen_1",  int'(seen[1]), 0);
        chk("flush_seen_2",  int'(seen[2]), 0);

        // Tag wrap: head=30, branch tag 0
        rob_head = 5'd30;
        foreach (seen[i]) seen[i] = 0;
        put(0, 31, 5, 1, 31); put(1, 1, 6, 1, 1);
        tick();
        mp = 1; mtag = 5'd0;
        tick();
        drain(6);
        chk("wrap_seen_31", int'(seen[31]), 1);
        chk("wrap_seen_1",  int'(seen[1]), 0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 19) == 0) rob_head = TAG_W'($urandom);
            for (int s = 0; s < 3; s++)
                if ($urandom_range(0, 99) < 65)
                    put(s, int'($urandom_range(0, TMASK)), int'($urandom_range(0, 127)),
                        bit'($urandom_range(0, 1)), int'($urandom));
            if ($urandom_range(0, 99) < 6) begin
                mp = 1;
                mtag = TAG_W'($urandom);
            end
            tick();
        end
        drain(16);

        // Asynchronous reset while a broadcast is on the CDB and entries remain
        put(0, 7, 1, 1, 7); put(1, 8, 2, 1, 8); put(2, 9, 3, 1, 9);
        tick();
        tick();
        #2 rst = 1;
        #1;
        chk("async_rst_cdb_valid", int'(bus.cdb_valid), 0);
        check_ready();
        clear_model();
        @(posedge clk);
        #2 rst = 0;
        @(posedge clk);
        #1;
        drain(6);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
